// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-bus responder: bus request/response structs,
// access size encoding, FSM state enum, default base address and the
// byte-strobe merge helper.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [63:0] DMEM_BASE      = 64'h0000_0000_8000_0000;
  localparam logic [7:0]  DMEM_LFSR_SEED = 8'hA5;

  // Replace each byte of old_word whose strobe bit is set with the
  // corresponding byte of new_word.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strobe);
    logic [63:0] res;
    res = old_word;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-bus handshake bundle: request from the memory stage (master) and
// response from the responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dmem_responder_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter the responder
// latency. Advances one step per cycle with en_i high; reset loads the seed.
module dmem_lfsr
  import dmem_responder_pkg::*;
#(
  parameter logic [7:0] SEED = DMEM_LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value: shift left, feedback from taps 8,6,5,4 into bit 0.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: behavioural slave for the dbus handshake. Accepts one
// request at a time from IDLE, waits a fixed latency, then performs a
// byte-strobed access to an internal 64-bit-word RAM and pulses data_ok.
// Optional build macro DMEM_LFSR_JITTER_EN adds 0..3 cycles of
// pseudo-random extra latency per request.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = DMEM_BASE
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    dbus,
  output logic               busy,
  output logic               oor_err
);

  localparam int          WORDS     = 1 << DEPTH_LOG2;
  // Number of WAIT cycles before any jitter is added.
  localparam logic [4:0]  WAIT_BASE = 5'(LATENCY - 1);

  logic [63:0] mem_q [WORDS];

  dmem_state_t state_q;
  logic [4:0]  cnt_q;
  logic [63:0] addr_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic [63:0] data_q;
  logic        data_ok_q;
  logic        oor_q;

  logic                  accept_s;
  logic [1:0]            jit_s;
  logic [4:0]            wait_total_s;
  logic                  access_s;
  logic [63:0]           acc_addr_s;
  logic [7:0]            acc_strobe_s;
  logic [63:0]           acc_wdata_s;
  logic [63:0]           off_s;
  logic                  in_range_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [63:0]           merged_s;
  logic                  mem_we_s;

  assign accept_s = (state_q == IDLE) && dbus.dreq.valid;

`ifdef DMEM_LFSR_JITTER_EN
  logic [7:0] lfsr_s;

  dmem_lfsr #(.SEED(DMEM_LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en_i  (accept_s),
    .q_o   (lfsr_s)
  );

  // Extra latency comes from the LFSR value current at the accept cycle.
  assign jit_s = lfsr_s[1:0];
`else
  assign jit_s = 2'b00;
`endif

  assign wait_total_s = WAIT_BASE + {3'b000, jit_s};

  // Access happens on the edge entering RESP: either straight from IDLE
  // (no WAIT cycles) or when the WAIT counter has run out.
  assign access_s = (accept_s && (wait_total_s == 5'd0)) ||
                    ((state_q == WAIT) && (cnt_q == 5'd0));

  // Access operands: live request when accessing straight from IDLE,
  // latched request otherwise.
  always_comb begin
    acc_addr_s   = addr_q;
    acc_strobe_s = strobe_q;
    acc_wdata_s  = wdata_q;
    if (state_q == IDLE) begin
      acc_addr_s   = dbus.dreq.addr;
      acc_strobe_s = dbus.dreq.strobe;
      acc_wdata_s  = dbus.dreq.data;
    end else begin
      acc_addr_s   = addr_q;
      acc_strobe_s = strobe_q;
      acc_wdata_s  = wdata_q;
    end
  end

  // Word index ignores addr[2:0]; range check covers both below-base
  // addresses and indices past the end of the RAM.
  assign off_s      = acc_addr_s - BASE_ADDR;
  assign in_range_s = (acc_addr_s >= BASE_ADDR) &&
                      ((off_s >> (DEPTH_LOG2 + 3)) == 64'd0);
  assign idx_s      = off_s[DEPTH_LOG2+2:3];
  assign merged_s   = merge_bytes(mem_q[idx_s], acc_wdata_s, acc_strobe_s);
  assign mem_we_s   = access_s && in_range_s && !reset;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      addr_q    <= 64'd0;
      strobe_q  <= 8'd0;
      wdata_q   <= 64'd0;
      data_q    <= 64'd0;
      data_ok_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      oor_q     <= 1'b0;
      if (access_s) begin
        data_q    <= in_range_s ? merged_s : 64'd0;
        oor_q     <= !in_range_s;
        data_ok_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (dbus.dreq.valid) begin
            addr_q   <= dbus.dreq.addr;
            strobe_q <= dbus.dreq.strobe;
            wdata_q  <= dbus.dreq.data;
            if (wait_total_s == 5'd0) begin
              state_q <= RESP;
              cnt_q   <= 5'd0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= wait_total_s - 5'd1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == 5'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= 5'd0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign dbus.dresp.addr_ok = accept_s;
  assign dbus.dresp.data_ok = data_ok_q;
  assign dbus.dresp.data    = data_q;
  assign busy               = (state_q != IDLE);
  assign oor_err            = oor_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: table of directed requests with
// hand-computed results, plus hand-written reset-mid-op, back-to-back and
// repeat-after-reset sequences. Latency expectations follow a reference
// LFSR when DMEM_LFSR_JITTER_EN is defined.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int L0 = 2;

  logic clk = 1'b0;
  logic reset;
  logic busy, oor_err, busy1, oor1;

  dmem_responder_if dbus ();
  dmem_responder_if dbus1 ();

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(12), .LATENCY(L0), .BASE_ADDR(64'h8000_0000)) u_dut (
    .clk(clk), .reset(reset), .dbus(dbus), .busy(busy), .oor_err(oor_err)
  );

  dmem_responder #(.DEPTH_LOG2(4), .LATENCY(1), .BASE_ADDR(64'h8000_0000)) u_dut1 (
    .clk(clk), .reset(reset), .dbus(dbus1), .busy(busy1), .oor_err(oor1)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] m_lfsr = 8'hA5;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_oor;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic int exp_lat();
`ifdef DMEM_LFSR_JITTER_EN
    return L0 + int'(m_lfsr[1:0]);
`else
    return L0;
`endif
  endfunction

  // Issue one request on dbus; entered and left 1 time unit after a rising edge with the DUT idle.
  task automatic do_req(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                        output logic [63:0] rd, output logic ro);
    int lat;
    int e;
    dbus.dreq.valid  = 1'b1;
    dbus.dreq.addr   = a;
    dbus.dreq.size   = MSIZE8;
    dbus.dreq.strobe = s;
    dbus.dreq.data   = d;
    #1;
    check("addr_ok", 64'(dbus.dresp.addr_ok), 64'd1);
    e = exp_lat();
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk); #1;
    dbus.dreq.valid = 1'b0;
    lat = 1;
    while (!dbus.dresp.data_ok && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(e));
    check("busy_in_resp", 64'(busy), 64'd1);
    rd = dbus.dresp.data;
    ro = oor_err;
    @(posedge clk); #1;
    check("data_ok_single", 64'(dbus.dresp.data_ok), 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        ro;
    int          acc, ok;
    logic [31:0] acc_mask, ok_mask;

    vecs[0]  = '{64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0};
    vecs[1]  = '{64'h8000_0010, 8'h00, 64'h0,                   64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{64'h8000_0013, 8'h08, 64'h0000_0000_AB00_0000, 64'h1122_3344_AB66_7788, 1'b0};
    vecs[3]  = '{64'h8000_0010, 8'h00, 64'h0,                   64'h1122_3344_AB66_7788, 1'b0};
    vecs[4]  = '{64'h8000_0014, 8'h30, 64'h0000_CDEF_0000_0000, 64'h1122_CDEF_AB66_7788, 1'b0};
    vecs[5]  = '{64'h8000_0015, 8'h00, 64'h0,                   64'h1122_CDEF_AB66_7788, 1'b0};
    vecs[6]  = '{64'h8000_0000, 8'hFF, 64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555, 1'b0};
    vecs[7]  = '{64'h8000_7FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[8]  = '{64'h7FFF_FFF8, 8'h00, 64'h0,                   64'h0,                   1'b1};
    vecs[9]  = '{64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                   1'b1};
    vecs[10] = '{64'h8000_0000, 8'h00, 64'h0,                   64'hAAAA_5555_AAAA_5555, 1'b0};
    vecs[11] = '{64'h8000_7FF8, 8'h00, 64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[12] = '{64'h0000_0000, 8'hFF, 64'h1,                   64'h0,                   1'b1};

    reset = 1'b1;
    dbus.dreq  = '0;
    dbus1.dreq = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_data",    dbus.dresp.data, 64'd0);
    check("rst_data_ok", 64'(dbus.dresp.data_ok), 64'd0);
    check("rst_oor",     64'(oor_err), 64'd0);
    reset  = 1'b0;
    m_lfsr = 8'hA5;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].addr, vecs[i].strobe, vecs[i].wdata, rd, ro);
      check($sformatf("data[%0d]", i), rd, vecs[i].exp_data);
      check($sformatf("oor[%0d]", i), 64'(ro), 64'(vecs[i].exp_oor));
      check($sformatf("hold[%0d]", i), dbus.dresp.data, vecs[i].exp_data);
      check($sformatf("oor_clr[%0d]", i), 64'(oor_err), 64'd0);
    end

    // Reset during WAIT of a store: the store must be dropped.
    dbus.dreq.valid  = 1'b1;
    dbus.dreq.addr   = 64'h8000_0010;
    dbus.dreq.strobe = 8'hFF;
    dbus.dreq.data   = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk); #1;
    dbus.dreq.valid = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",    64'(busy), 64'd0);
    check("mid_rst_data",    dbus.dresp.data, 64'd0);
    check("mid_rst_data_ok", 64'(dbus.dresp.data_ok), 64'd0);
    check("mid_rst_addr_ok", 64'(dbus.dresp.addr_ok), 64'd0);
    m_lfsr = 8'hA5;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(64'h8000_0010, 8'h00, 64'h0, rd, ro);
    check("after_rst_old_word", rd, 64'h1122_CDEF_AB66_7788);

    // Back-to-back on the LATENCY=1 instance with valid held high.
    acc = 0; ok = 0; acc_mask = 32'd0; ok_mask = 32'd0;
    dbus1.dreq.valid  = 1'b1;
    dbus1.dreq.addr   = 64'h8000_0000;
    dbus1.dreq.size   = MSIZE8;
    dbus1.dreq.strobe = 8'h00;
    dbus1.dreq.data   = 64'h0;
    for (int c = 0; c < 30; c++) begin
      if (acc == 3) dbus1.dreq.valid = 1'b0;
      #1;
      if (dbus1.dresp.addr_ok) begin acc++; acc_mask[c] = 1'b1; end
      if (dbus1.dresp.data_ok) begin ok++;  ok_mask[c]  = 1'b1; end
      @(posedge clk); #1;
    end
    check("b2b_accepts",  64'(acc), 64'd3);
    check("b2b_data_oks", 64'(ok),  64'd3);
`ifndef DMEM_LFSR_JITTER_EN
    check("b2b_accept_cycles",  64'(acc_mask), 64'h15);
    check("b2b_data_ok_cycles", 64'(ok_mask),  64'h2A);
`endif

    // Second reset: latency sequence restarts from the seed.
    reset = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    m_lfsr = 8'hA5;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      do_req(64'h8000_0000, 8'h00, 64'h0, rd, ro);
      check($sformatf("rep_data[%0d]", i), rd, 64'hAAAA_5555_AAAA_5555);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Behavioural data-bus responder: the slave end of the `dbus_req_t`/`dbus_resp_t` handshake that the memory stage drives. It accepts one request at a time, models a fixed (optionally jittered) access latency, and applies byte-strobed writes to / reads from an internal doubleword-organised RAM. It returns one `data_ok` pulse per request. Used in simulation tops and unit benches in place of the cache/bus fabric.

## Interface
- `DEPTH_LOG2`, 12: RAM holds 2^DEPTH_LOG2 64-bit words.
- `LATENCY`, 2: cycles from accept to `data_ok`; legal range 1..15.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dreq`  in  `dbus_req_t`  request: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data`.
- `busy`  out  1  a request is held (state ≠ IDLE).
- `oor_err`  out  1  pulses with `data_ok` when the held address is out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `dresp.addr_ok = dreq.valid` (combinational).
  - When `valid` is set, latch addr, strobe and data, then go to WAIT with counter = LATENCY-1. If LATENCY=1, go straight to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - At the edge where the counter is 0, perform the access and go to RESP.
  - `dreq` is ignored while in this state.
- Access, done at the single edge entering RESP:
  - Index = `(addr - BASE_ADDR) >> 3`. The address is in range iff `addr >= BASE_ADDR` and the index is < 2^DEPTH_LOG2.
  - `addr[2:0]` and `size` are ignored. `strobe` is authoritative: byte i is written from `data[8i+7:8i]` when `strobe[i]=1`.
  - The registered response word is the merged post-write word. For reads (strobe=0) this is the stored word.
  - The full aligned doubleword is returned. The requester shifts it.
  - Out of range: no write; response word = 0; `oor_err` is set for the RESP cycle.
- RESP:
  - `data_ok=1` for exactly one cycle, then IDLE.
  - `dresp.data` holds its value until the next access edge.
  - A `valid` present during RESP is not accepted. Acceptance happens only from IDLE.
- Reset, including mid-operation:
  - Clears to IDLE, counter 0, `dresp` all-zero, `busy=0`, `oor_err=0`, jitter LFSR to seed.
  - RAM contents are not reset.
  - A write not yet at its access edge is dropped.
- RAM is initialised to zero at time 0. An optional `$readmemh` of a file named by plusarg `DMEM_INIT` is allowed.

## Timing
- Accept in cycle t (`addr_ok=1`). `data_ok` falls in cycle t+LATENCY (+jitter if enabled).
- The earliest next accept is cycle t+LATENCY+1. Per request: 1 accept cycle, LATENCY-1 WAIT cycles, 1 RESP cycle.
- A requester that drops `valid` the cycle after `data_ok` sees no duplicate accept.
- A requester that keeps `valid` high after RESP starts a new transaction at the next IDLE cycle.
- `addr_ok` is combinational from `dreq.valid` and state. `data_ok`, `data` and `oor_err` are registered.

## Configuration
- `DMEM_LFSR_JITTER_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5) advances once per accept.
  - Its low 2 bits are added to the WAIT count, so latency = LATENCY..LATENCY+3.
  - The sequence is deterministic from reset.
- Undefined: latency is exactly LATENCY and no LFSR logic exists.

## Structure
- Shared package (`common`): `dmem_state_t` enum {IDLE, WAIT, RESP}; a `DMEM_BASE` constant used as the BASE_ADDR default.
- `dbus_req_t`, `dbus_resp_t` and `msize_t` are reused unchanged.
- Sub-module `dmem_lfsr` (8-bit, enable, async reset), instantiated only under the macro.
- RAM and strobe merge stay inline.

## Test plan
- Write then read:
  - SD to 0x8000_0010, strobe 8'hFF, data 64'h1122_3344_5566_7788, LATENCY=2 → `data_ok` at t+2.
  - LD same address → `data` = 64'h1122_3344_5566_7788.
- Byte strobe:
  - SB to 0x8000_0013, strobe 8'h08, data 64'hAB00_0000 → LD 0x8000_0010 returns 64'h1122_3344_AB66_7788.
- Out of range:
  - LD at 0x7FFF_FFF8 → `data=0` and `oor_err=1` in the `data_ok` cycle.
  - SD at BASE+8·2^DEPTH_LOG2 → RAM unchanged.
- Back-to-back:
  - `valid` held high for 3 requests, LATENCY=1 → `data_ok` at t+1, t+3, t+5; exactly 3 accepts.
- Reset mid-op:
  - Assert `reset` during WAIT of an SD → `busy=0`, `dresp` = 0 immediately.
  - Subsequent LD returns the old word.
- Jitter (macro on):
  - 16 requests → every latency in [LATENCY, LATENCY+3].
  - The sequence repeats identically after a second reset.
